// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the machine-mode CSR unit.
//   - CSR address map
//   - mstatus field positions, privilege encodings, csr_op encodings
//   - interrupt cause codes and WARL masks
//   - csr_wval(): the RW/RS/RC write-value function
package csr_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTEREN    = 12'h306;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  // mstatus field positions
  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  typedef enum logic [1:0] {
    UMODE = 2'b00,
    MMODE = 2'b11
  } priv_e;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  // Interrupt cause codes (also their bit positions in mip/mie)
  localparam logic [3:0] IRQ_CODE_MEI = 4'd11;
  localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
  localparam logic [3:0] IRQ_CODE_MSI = 4'd3;

  localparam logic [31:0] MISA_VAL    = 32'h4000_0100;
  localparam logic [31:0] MIE_MASK    = 32'h0000_0888;
  localparam logic [31:0] CNT_EN_MASK = 32'h0000_0005;

  function automatic logic [31:0] csr_wval(input csr_op_e op, input logic [31:0] old_v,
                                           input logic [31:0] src);
    case (op)
      CSR_OP_RS: return old_v | src;
      CSR_OP_RC: return old_v & ~src;
      default:   return src;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter.sv
// csr_counter: CNT_W-bit performance counter exposed as two 32-bit CSR halves.
//   clk_i      clock (state updates on the falling edge)
//   reset_ni   synchronous active-low reset
//   inc_i      increment request this cycle
//   inhibit_i  suppress increment
//   wr_lo_i    replace bits 31:0 with wdata_i
//   wr_hi_i    replace bits CNT_W-1:32 with wdata_i
//   wdata_i    write data
//   value_o    counter value, zero-extended to 64 bits
module csr_counter #(
  parameter int unsigned CNT_W = 64
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        inc_i,
  input  logic        inhibit_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A CSR write to either half takes precedence over the increment.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i) begin
      cnt_d[31:0] = wdata_i;
    end else if (wr_hi_i) begin
      cnt_d[CNT_W-1:32] = wdata_i[CNT_W-33:0];
    end else if (inc_i && !inhibit_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(negedge clk_i) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = 64'(cnt_q);

endmodule

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file for the RV32 core.
//   clk          clock; all state updates on the falling edge
//   reset_x      synchronous active-low reset
//   csr_addr/csr_op/csr_wdata  CSR access (op 00 none, 01 RW, 10 RS, 11 RC)
//   csr_rdata    old value of csr_addr (0 when illegal)
//   csr_illegal  access is illegal; its write is suppressed
//   exception/exc_cause/exc_pc/exc_tval  synchronous trap entry
//   take_irq     controller accepts irq_req (exc_pc = interrupted pc)
//   mret         return from trap
//   instret      instruction retires
//   irq_ext/irq_timer/irq_sw  level interrupt sources
//   irq_req, trap_pc, mepc_out, priv_mode  status to the controller
module csr_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] HART_ID   = 32'd0,
  parameter bit          VECTORED  = 1'b1,
  parameter int unsigned CNT_W     = 64,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_op,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        exception,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        take_irq,
  input  logic        mret,
  input  logic        instret,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        irq_sw,
  output logic        irq_req,
  output logic [31:0] trap_pc,
  output logic [31:0] mepc_out,
  output logic [1:0]  priv_mode
);

  priv_e       priv_q, priv_d;
  priv_e       mpp_q, mpp_d;
  logic        mie_bit_q, mie_bit_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mcounteren_q, mcounteren_d;
  logic [31:0] mcountinhibit_q, mcountinhibit_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;

  logic [63:0] mcycle, minstret;
  logic [31:0] mstatus_rd, mip_rd, pend, rdata_raw, wval, tvec_base;
  logic [3:0]  irq_code;
  logic [1:0]  priv_bits;
  logic        impl, op_writes, cnt_u_block, take_eff, mret_eff, csr_we;
  csr_op_e     op_e;

  assign op_e      = csr_op_e'(csr_op);
  assign priv_bits = priv_q;

  always_comb begin
    mstatus_rd                                = '0;
    mstatus_rd[MSTATUS_MIE]                   = mie_bit_q;
    mstatus_rd[MSTATUS_MPIE]                  = mpie_q;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mpp_q;
    mip_rd               = '0;
    mip_rd[IRQ_CODE_MEI] = irq_ext;
    mip_rd[IRQ_CODE_MTI] = irq_timer;
    mip_rd[IRQ_CODE_MSI] = irq_sw;
  end

  // Interrupt selection: external > software > timer.
  assign pend    = mie_q & mip_rd;
  assign irq_req = (|pend) && ((priv_q == UMODE) || mie_bit_q);

  always_comb begin
    if (pend[IRQ_CODE_MEI])      irq_code = IRQ_CODE_MEI;
    else if (pend[IRQ_CODE_MSI]) irq_code = IRQ_CODE_MSI;
    else if (pend[IRQ_CODE_MTI]) irq_code = IRQ_CODE_MTI;
    else                         irq_code = 4'd0;
  end

  assign tvec_base = {mtvec_q[31:2], 2'b00};
  assign trap_pc   = (!exception && irq_req && (mtvec_q[1:0] == 2'b01))
                     ? tvec_base + {26'b0, irq_code, 2'b00} : tvec_base;

  // Read decode; also flags whether the address is implemented.
  always_comb begin
    impl      = 1'b1;
    rdata_raw = '0;
    case (csr_addr)
      CSR_MSTATUS:       rdata_raw = mstatus_rd;
      CSR_MISA:          rdata_raw = MISA_VAL;
      CSR_MIE:           rdata_raw = mie_q;
      CSR_MTVEC:         rdata_raw = mtvec_q;
      CSR_MCOUNTEREN:    rdata_raw = mcounteren_q;
      CSR_MCOUNTINHIBIT: rdata_raw = mcountinhibit_q;
      CSR_MSCRATCH:      rdata_raw = mscratch_q;
      CSR_MEPC:          rdata_raw = mepc_q;
      CSR_MCAUSE:        rdata_raw = mcause_q;
      CSR_MTVAL:         rdata_raw = mtval_q;
      CSR_MIP:           rdata_raw = mip_rd;
      CSR_MCYCLE,    CSR_CYCLE:    rdata_raw = mcycle[31:0];
      CSR_MCYCLEH,   CSR_CYCLEH:   rdata_raw = mcycle[63:32];
      CSR_MINSTRET,  CSR_INSTRET:  rdata_raw = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rdata_raw = minstret[63:32];
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rdata_raw = '0;
      CSR_MHARTID:       rdata_raw = HART_ID;
      default:           impl = 1'b0;
    endcase
  end

  // RS/RC with a zero operand never write, so they are legal on read-only CSRs.
  assign op_writes   = (op_e == CSR_OP_RW) || (csr_wdata != '0);
  assign cnt_u_block = (priv_q == UMODE) &&
                       ((((csr_addr == CSR_CYCLE) || (csr_addr == CSR_CYCLEH)) && !mcounteren_q[0]) ||
                        (((csr_addr == CSR_INSTRET) || (csr_addr == CSR_INSTRETH)) && !mcounteren_q[2]));
  assign csr_illegal = (op_e != CSR_OP_NONE) &&
                       (!impl || (priv_bits < csr_addr[9:8]) ||
                        ((csr_addr[11:10] == 2'b11) && op_writes) || cnt_u_block);
  assign csr_rdata   = csr_illegal ? '0 : rdata_raw;

  assign wval     = csr_wval(op_e, rdata_raw, csr_wdata);
  assign take_eff = take_irq && irq_req;
  assign mret_eff = mret && (priv_q == MMODE);
  assign csr_we   = (op_e != CSR_OP_NONE) && op_writes && !csr_illegal &&
                    !exception && !take_eff && !mret_eff;

  always_comb begin
    priv_d          = priv_q;
    mpp_d           = mpp_q;
    mie_bit_d       = mie_bit_q;
    mpie_d          = mpie_q;
    mie_d           = mie_q;
    mtvec_d         = mtvec_q;
    mcounteren_d    = mcounteren_q;
    mcountinhibit_d = mcountinhibit_q;
    mscratch_d      = mscratch_q;
    mepc_d          = mepc_q;
    mcause_d        = mcause_q;
    mtval_d         = mtval_q;
    if (exception || take_eff) begin
      mepc_d    = {exc_pc[31:2], 2'b00};
      mcause_d  = exception ? {28'b0, exc_cause} : {1'b1, 27'b0, irq_code};
      mtval_d   = exception ? exc_tval : '0;
      mpie_d    = mie_bit_q;
      mie_bit_d = 1'b0;
      mpp_d     = priv_q;
      priv_d    = MMODE;
    end else if (mret_eff) begin
      mie_bit_d = mpie_q;
      mpie_d    = 1'b1;
      priv_d    = mpp_q;
      mpp_d     = UMODE;
    end else if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_bit_d = wval[MSTATUS_MIE];
          mpie_d    = wval[MSTATUS_MPIE];
          mpp_d     = (wval[MSTATUS_MPP_HI:MSTATUS_MPP_LO] == 2'b11) ? MMODE : UMODE;
        end
        CSR_MIE:           mie_d           = wval & MIE_MASK;
        CSR_MTVEC:         mtvec_d         = {wval[31:2],
                                              (VECTORED && (wval[1:0] == 2'b01)) ? 2'b01 : 2'b00};
        CSR_MCOUNTEREN:    mcounteren_d    = wval & CNT_EN_MASK;
        CSR_MCOUNTINHIBIT: mcountinhibit_d = wval & CNT_EN_MASK;
        CSR_MSCRATCH:      mscratch_d      = wval;
        CSR_MEPC:          mepc_d          = {wval[31:2], 2'b00};
        CSR_MCAUSE:        mcause_d        = wval;
        CSR_MTVAL:         mtval_d         = wval;
        default: ;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (!reset_x) begin
      priv_q          <= MMODE;
      mpp_q           <= UMODE;
      mie_bit_q       <= 1'b0;
      mpie_q          <= 1'b0;
      mie_q           <= '0;
      mtvec_q         <= MTVEC_RST;
      mcounteren_q    <= '0;
      mcountinhibit_q <= '0;
      mscratch_q      <= '0;
      mepc_q          <= '0;
      mcause_q        <= '0;
      mtval_q         <= '0;
    end else begin
      priv_q          <= priv_d;
      mpp_q           <= mpp_d;
      mie_bit_q       <= mie_bit_d;
      mpie_q          <= mpie_d;
      mie_q           <= mie_d;
      mtvec_q         <= mtvec_d;
      mcounteren_q    <= mcounteren_d;
      mcountinhibit_q <= mcountinhibit_d;
      mscratch_q      <= mscratch_d;
      mepc_q          <= mepc_d;
      mcause_q        <= mcause_d;
      mtval_q         <= mtval_d;
    end
  end

  csr_counter #(.CNT_W(CNT_W)) u_mcycle (
    .clk_i    (clk),
    .reset_ni (reset_x),
    .inc_i    (1'b1),
    .inhibit_i(mcountinhibit_q[0]),
    .wr_lo_i  (csr_we && (csr_addr == CSR_MCYCLE)),
    .wr_hi_i  (csr_we && (csr_addr == CSR_MCYCLEH)),
    .wdata_i  (wval),
    .value_o  (mcycle)
  );

  csr_counter #(.CNT_W(CNT_W)) u_minstret (
    .clk_i    (clk),
    .reset_ni (reset_x),
    .inc_i    (instret && !exception),
    .inhibit_i(mcountinhibit_q[2]),
    .wr_lo_i  (csr_we && (csr_addr == CSR_MINSTRET)),
    .wr_hi_i  (csr_we && (csr_addr == CSR_MINSTRETH)),
    .wdata_i  (wval),
    .value_o  (minstret)
  );

  assign mepc_out  = mepc_q;
  assign priv_mode = priv_q;

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed test of csr_unit. Inputs change 1ns after the rising
// edge; state commits on the falling edge; outputs are sampled between.
`timescale 1ns/1ps
module tb_csr_unit;

  localparam logic [1:0] OP_NONE = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11;
  localparam logic [3:0] C_NONE = 4'b0000, C_EXC = 4'b1000, C_TAKE = 4'b0100,
                         C_MRET = 4'b0010, C_RET = 4'b0001;

  logic        clk = 1'b0;
  logic        reset_x = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [1:0]  csr_op = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        exception = 1'b0;
  logic [3:0]  exc_cause = '0;
  logic [31:0] exc_pc = '0;
  logic [31:0] exc_tval = '0;
  logic        take_irq = 1'b0;
  logic        mret = 1'b0;
  logic        instret = 1'b0;
  logic        irq_ext = 1'b0;
  logic        irq_timer = 1'b0;
  logic        irq_sw = 1'b0;
  logic        irq_req;
  logic [31:0] trap_pc;
  logic [31:0] mepc_out;
  logic [1:0]  priv_mode;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;
  logic [31:0] got_rd, got_tpc;
  logic        got_ill;

  csr_unit #(
    .HART_ID  (32'd3),
    .VECTORED (1'b1),
    .CNT_W    (64),
    .MTVEC_RST(32'h0000_0080)
  ) dut (
    .clk(clk), .reset_x(reset_x),
    .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .exception(exception), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .take_irq(take_irq), .mret(mret), .instret(instret),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw),
    .irq_req(irq_req), .trap_pc(trap_pc), .mepc_out(mepc_out), .priv_mode(priv_mode)
  );

  always #10 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Start of a sampling window (between rising and falling edge).
  task automatic win();
    @(posedge clk);
    #1;
  endtask

  task automatic rdchk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_op   = OP_NONE;
    csr_addr = a;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  // One cycle: drive op and controls, sample outputs, let the falling edge commit.
  task automatic cyc(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                     input logic [3:0] ctl);
    win();
    csr_op    = op;
    csr_addr  = a;
    csr_wdata = wd;
    {exception, take_irq, mret, instret} = ctl;
    #1;
    got_rd  = csr_rdata;
    got_ill = csr_illegal;
    got_tpc = trap_pc;
    @(negedge clk);
    #1;
    csr_op = OP_NONE;
    csr_wdata = '0;
    {exception, take_irq, mret, instret} = C_NONE;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    win();
    reset_x = 1'b1;
    rdchk("mstatus_rst", 12'h300, 32'h0);
    rdchk("mtvec_rst",   12'h305, 32'h80);
    rdchk("mcycle_rst",  12'hB00, 32'h0);
    chk("priv_rst", 32'(priv_mode), 32'h3);
    chk("mepc_rst", mepc_out, 32'h0);
    chk("irq_rst",  32'(irq_req), 32'h0);

    repeat (10) @(negedge clk);
    win();
    rdchk("mcycle_10", 12'hB00, 32'd10);
    rdchk("misa",      12'h301, 32'h4000_0100);
    rdchk("mhartid",   12'hF14, 32'h3);
    rdchk("mvendorid", 12'hF11, 32'h0);
    rdchk("mip_idle",  12'h344, 32'h0);

    // mstatus RS/RC/RW and MPP legalisation
    cyc(OP_RS, 12'h300, 32'h1808, C_NONE);
    chk("rs_old", got_rd, 32'h0);
    chk("rs_legal", 32'(got_ill), 32'h0);
    cyc(OP_RC, 12'h300, 32'h8, C_NONE);
    chk("rc_old", got_rd, 32'h1808);
    cyc(OP_RW, 12'h300, 32'h0800, C_NONE);
    chk("rw_old", got_rd, 32'h1800);
    win();
    rdchk("mpp_warl", 12'h300, 32'h0);

    // mie mask, vectored mtvec, interrupt request
    cyc(OP_RW, 12'h304, 32'hFFFF_FFFF, C_NONE);
    win();
    rdchk("mie_warl", 12'h304, 32'h888);
    cyc(OP_RW, 12'h304, 32'h80, C_NONE);
    cyc(OP_RW, 12'h305, 32'h1001, C_NONE);
    cyc(OP_RS, 12'h300, 32'h8, C_NONE);
    win();
    rdchk("mtvec_vec", 12'h305, 32'h1001);
    irq_timer = 1'b1;
    #1;
    chk("irq_timer", 32'(irq_req), 32'h1);
    chk("tpc_timer", trap_pc, 32'h101C);
    rdchk("mip_timer", 12'h344, 32'h80);
    exc_pc = 32'h203;
    cyc(OP_NONE, 12'h0, 32'h0, C_TAKE);
    chk("tpc_take", got_tpc, 32'h101C);
    win();
    rdchk("mcause_irq", 12'h342, 32'h8000_0007);
    rdchk("mepc_irq",   12'h341, 32'h200);
    rdchk("mstat_irq",  12'h300, 32'h1880);
    rdchk("mtval_irq",  12'h343, 32'h0);
    chk("irq_masked", 32'(irq_req), 32'h0);

    // interrupt priority 11 > 3 > 7
    cyc(OP_RW, 12'h304, 32'h888, C_NONE);
    cyc(OP_RS, 12'h300, 32'h8, C_NONE);
    win();
    irq_sw = 1'b1;
    #1;
    chk("tpc_sw", trap_pc, 32'h100C);
    irq_ext = 1'b1;
    #1;
    chk("tpc_ext", trap_pc, 32'h102C);
    {irq_ext, irq_timer, irq_sw} = 3'b000;
    #1;
    chk("irq_clear", 32'(irq_req), 32'h0);
    exc_pc = 32'h444;
    cyc(OP_NONE, 12'h0, 32'h0, C_TAKE);
    win();
    rdchk("take_noirq", 12'h341, 32'h200);
    rdchk("take_noirq_st", 12'h300, 32'h1888);

    cyc(OP_RW, 12'h305, 32'h1002, C_NONE);
    win();
    rdchk("mtvec_mode2", 12'h305, 32'h1000);

    // drop to U-mode
    cyc(OP_RW, 12'h300, 32'h0080, C_NONE);
    cyc(OP_RW, 12'h341, 32'h403, C_NONE);
    win();
    rdchk("mepc_warl", 12'h341, 32'h400);
    cyc(OP_NONE, 12'h0, 32'h0, C_MRET);
    win();
    chk("priv_u", 32'(priv_mode), 32'h0);
    chk("mepc_out", mepc_out, 32'h400);

    cyc(OP_RW, 12'h305, 32'h5555, C_NONE);
    chk("u_mtvec_ill", 32'(got_ill), 32'h1);
    chk("u_mtvec_rd0", got_rd, 32'h0);
    cyc(OP_RS, 12'hC00, 32'h0, C_NONE);
    chk("u_cycle_ill", 32'(got_ill), 32'h1);
    cyc(OP_NONE, 12'h0, 32'h0, C_MRET);
    win();
    chk("mret_u_ign", 32'(priv_mode), 32'h0);
    irq_ext = 1'b1;
    #1;
    chk("irq_u", 32'(irq_req), 32'h1);
    chk("tpc_direct", trap_pc, 32'h1000);
    irq_ext = 1'b0;

    // exception from U-mode
    exc_cause = 4'd2; exc_tval = 32'h0BAD_F00D; exc_pc = 32'h808;
    cyc(OP_NONE, 12'h0, 32'h0, C_EXC);
    win();
    chk("priv_exc", 32'(priv_mode), 32'h3);
    rdchk("mcause_exc", 12'h342, 32'h2);
    rdchk("mtval_exc",  12'h343, 32'h0BAD_F00D);
    rdchk("mepc_exc",   12'h341, 32'h808);
    rdchk("mstat_exc",  12'h300, 32'h80);
    rdchk("mtvec_kept", 12'h305, 32'h1000);

    cyc(OP_RW, 12'h340, 32'h1111, C_NONE);
    cyc(OP_RW, 12'h306, 32'hFFFF_FFFF, C_NONE);
    win();
    rdchk("mscratch", 12'h340, 32'h1111);
    rdchk("mcounteren", 12'h306, 32'h5);
    cyc(OP_RW, 12'hC00, 32'h1, C_NONE);
    chk("ro_write_ill", 32'(got_ill), 32'h1);
    cyc(OP_RS, 12'hC00, 32'h0, C_NONE);
    chk("ro_read_ok", 32'(got_ill), 32'h0);

    // exception suppresses a same-cycle CSR write
    exc_tval = 32'hDEAD_BEEF; exc_pc = 32'h900;
    cyc(OP_RW, 12'h340, 32'h2222, C_EXC);
    win();
    rdchk("exc_suppress", 12'h340, 32'h1111);
    rdchk("mtval_beef",   12'h343, 32'hDEAD_BEEF);
    rdchk("mstat_exc2",   12'h300, 32'h1800);
    chk("priv_exc2", 32'(priv_mode), 32'h3);
    cyc(OP_NONE, 12'h0, 32'h0, C_MRET);
    win();
    chk("priv_mret", 32'(priv_mode), 32'h3);
    rdchk("mstat_mret", 12'h300, 32'h80);

    // U-mode counter read enabled by mcounteren
    cyc(OP_RW, 12'hB00, 32'h100, C_NONE);
    cyc(OP_NONE, 12'h0, 32'h0, C_MRET);
    cyc(OP_RS, 12'hC00, 32'h0, C_NONE);
    chk("u_cycle_ok", 32'(got_ill), 32'h0);
    chk("u_cycle_val", got_rd, 32'h101);
    exc_cause = 4'd3; exc_pc = 32'h0;
    cyc(OP_NONE, 12'h0, 32'h0, C_EXC);

    // 32-bit carry into the high half, then inhibit
    cyc(OP_RW, 12'hB80, 32'h0, C_NONE);
    cyc(OP_RW, 12'hB00, 32'hFFFF_FFFF, C_NONE);
    win();
    rdchk("cyc_lo_max", 12'hB00, 32'hFFFF_FFFF);
    rdchk("cyc_hi_0",   12'hB80, 32'h0);
    win();
    rdchk("cyc_lo_wrap", 12'hB00, 32'h0);
    rdchk("cyc_hi_1",    12'hB80, 32'h1);
    rdchk("cycleh_shad", 12'hC80, 32'h1);
    cyc(OP_RW, 12'h320, 32'hFFFF, C_NONE);
    win();
    rdchk("inhibit_warl", 12'h320, 32'h5);
    rdchk("cyc_frozen0",  12'hB00, 32'h2);
    repeat (3) @(negedge clk);
    win();
    rdchk("cyc_frozen3", 12'hB00, 32'h2);

    // minstret: inhibit, exception gating, write beats increment
    cyc(OP_NONE, 12'h0, 32'h0, C_RET);
    win();
    rdchk("ret_inhib", 12'hB02, 32'h0);
    cyc(OP_RW, 12'h320, 32'h0, C_NONE);
    cyc(OP_NONE, 12'h0, 32'h0, C_RET);
    win();
    rdchk("ret_inc", 12'hB02, 32'h1);
    cyc(OP_NONE, 12'h0, 32'h0, C_RET | C_EXC);
    win();
    rdchk("ret_exc", 12'hB02, 32'h1);
    cyc(OP_RW, 12'hB02, 32'h50, C_RET);
    win();
    rdchk("ret_wr_wins", 12'hB02, 32'h50);
    cyc(OP_NONE, 12'h0, 32'h0, C_RET);
    win();
    rdchk("instret_shad", 12'hC02, 32'h51);
    rdchk("minstreth",    12'hB82, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
